// File: rtl/fetch_request_unit.sv
// fetch_request_unit: owns the PC, sequences the instruction/data memory
// handshakes for each instruction, latches HALT and counts retirements.
// One instruction retires per commit pulse; memory instructions spend one
// extra phase (DATA) waiting for the data-memory hit.
module fetch_request_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [WORD_W-1:0] imemload,
  input  logic [WORD_W-1:0] rdat1,
  input  logic              dMemRe,
  input  logic              dMemWr,
  input  logic              Halt,
  input  logic              PcSrc,
  input  logic              JType,
  input  logic              JReg,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              commit,
  output logic              halt,
  output logic [WORD_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] count_q;
  logic        halt_q;

  logic [31:0] npc_d;
  logic [31:0] br_off_s;
  logic        mem_op_s;

  assign mem_op_s    = dMemRe | dMemWr;
  assign pc          = pc_q;
  assign imemaddr    = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_count = count_q;
  assign halt        = halt_q;
  assign br_off_s    = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Instruction presented downstream: live memory word while fetching,
  // the latched word once the fetch has completed (memory phase / halted).
  always_comb begin
    instr = instr_q;
    if (state_q == FETCH) begin
      instr = imemload;
    end else begin
      instr = instr_q;
    end
  end

  // Next-PC selection: JR beats J/JAL beats taken branch beats sequential.
  always_comb begin
    npc_d = pc_plus4;
    if (JReg) begin
      npc_d = rdat1;
    end else if (JType) begin
      npc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (PcSrc) begin
      npc_d = pc_plus4 + br_off_s;
    end else begin
      npc_d = pc_plus4;
    end
  end

  // Memory requests and retire strobe; all forced low while reset is held
  // so an in-flight data request is withdrawn in the reset cycle itself.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    commit  = 1'b0;
    if (nRST) begin
      case (state_q)
        FETCH: begin
          imemREN = 1'b1;
          commit  = ihit & ~Halt & ~mem_op_s;
        end
        DATA: begin
          dmemREN = dMemRe;
          dmemWEN = dMemWr;
          commit  = dhit;
        end
        HALTED: begin
          commit = 1'b0;
        end
        default: begin
          commit = 1'b0;
        end
      endcase
    end else begin
      commit = 1'b0;
    end
  end

  // Sequencer: state, PC, latched instruction, halt latch and retire count.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= 32'h0000_0000;
      count_q <= 32'h0000_0000;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            if (Halt) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
              instr_q <= imemload;
            end else if (mem_op_s) begin
              state_q <= DATA;
              instr_q <= imemload;
            end else begin
              pc_q    <= npc_d;
              count_q <= count_q + 32'd1;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            state_q <= FETCH;
            pc_q    <= npc_d;
            count_q <= count_q + 32'd1;
          end
        end
        HALTED: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed bench for fetch_request_unit: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_fetch_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit;
  logic [31:0] imemload, rdat1;
  logic        dMemRe, dMemWr, Halt, PcSrc, JType, JReg;
  logic        imemREN, dmemREN, dmemWEN, commit, halt;
  logic [31:0] imemaddr, instr, pc, pc_plus4, instr_count;

  int checks   = 0;
  int failures = 0;

  fetch_request_unit #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .imemload(imemload),
    .rdat1(rdat1), .dMemRe(dMemRe), .dMemWr(dMemWr), .Halt(Halt),
    .PcSrc(PcSrc), .JType(JType), .JReg(JReg), .imemREN(imemREN),
    .imemaddr(imemaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4), .commit(commit), .halt(halt),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    ihit = 1'b0; dhit = 1'b0; imemload = 32'h0; rdat1 = 32'h0;
    dMemRe = 1'b0; dMemWr = 1'b0; Halt = 1'b0; PcSrc = 1'b0;
    JType = 1'b0; JReg = 1'b0;
  endtask

  // one-cycle fetch of a non-memory instruction that retires immediately
  task automatic retire_fetch(input logic [31:0] word, input logic pcsrc,
                              input logic jt, input logic jr, input logic [31:0] r1);
    @(negedge CLK);
    idle(); ihit = 1'b1; imemload = word; PcSrc = pcsrc; JType = jt; JReg = jr; rdat1 = r1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b0; idle(); ihit = 1'b1; dhit = 1'b1; dMemRe = 1'b1;
    #1;
    checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL rst_imemren got=%0b exp=0", imemREN); end
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%0b exp=0", commit); end
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%0b exp=0", halt); end
    checks++; if (instr_count !== 32'h0) begin failures++; $display("FAIL rst_count got=%0d exp=0", instr_count); end
    idle(); nRST = 1'b1; #1;
    checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL rel_imemren got=%0b exp=1", imemREN); end
    checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL rel_imemaddr got=%h exp=0", imemaddr); end
  endtask

  task automatic test_alu_delayed();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); idle(); imemload = 32'h0022_1821; #1;
      checks++; if (commit !== 1'b0) begin failures++; $display("FAIL wait_commit got=%0b exp=0", commit); end
      @(posedge CLK); #1;
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wait_pc got=%h exp=0", pc); end
    end
    @(negedge CLK); ihit = 1'b1; #1;
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL alu_commit got=%0b exp=1", commit); end
    @(posedge CLK); #1;
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL alu_pc got=%h exp=4", pc); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL alu_count got=%0d exp=1", instr_count); end
    @(negedge CLK); idle(); #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%0b exp=0", commit); end
  endtask

  task automatic test_load();
    // J to 0x10 (target field 4)
    retire_fetch(32'h0800_0004, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL j_pc got=%h exp=10", pc); end
    @(negedge CLK); idle(); ihit = 1'b1; dMemRe = 1'b1; imemload = 32'h8C43_0000; #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL lw_fetch_commit got=%0b exp=0", commit); end
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); ihit = 1'b1; imemload = 32'hDEAD_BEEF; #1;
      checks++; if (imemREN !== 1'b0 || dmemREN !== 1'b1 || dmemWEN !== 1'b0) begin
        failures++; $display("FAIL lw_req got=%0b%0b%0b exp=010", imemREN, dmemREN, dmemWEN); end
      checks++; if (instr !== 32'h8C43_0000) begin failures++; $display("FAIL lw_instr got=%h exp=8c430000", instr); end
      checks++; if (commit !== 1'b0 || pc !== 32'h10) begin failures++; $display("FAIL lw_hold commit=%0b pc=%h exp 0/10", commit, pc); end
    end
    @(negedge CLK); dhit = 1'b1; #1;
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL lw_commit got=%0b exp=1", commit); end
    @(posedge CLK); #1;
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL lw_pc got=%h exp=14", pc); end
    checks++; if (instr_count !== 32'd3) begin failures++; $display("FAIL lw_count got=%0d exp=3", instr_count); end
    @(negedge CLK); idle(); #1;
    checks++; if (imemREN !== 1'b1 || dmemREN !== 1'b0) begin failures++; $display("FAIL lw_back got=%0b%0b exp=10", imemREN, dmemREN); end
  endtask

  task automatic test_branch_jumps();
    retire_fetch(32'h0800_0008, 1'b0, 1'b1, 1'b0, 32'h0);   // J 0x20
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL j2_pc got=%h exp=20", pc); end
    retire_fetch(32'h1022_FFFF, 1'b1, 1'b0, 1'b0, 32'h0);   // BEQ taken, imm -1
    checks++; if (pc !== 32'h20) begin failures++; $display("FAIL beq_pc got=%h exp=20", pc); end
    @(negedge CLK); idle(); imemload = 32'h0C00_0040; JType = 1'b1; #1;
    checks++; if (pc_plus4 !== 32'h24) begin failures++; $display("FAIL jal_link got=%h exp=24", pc_plus4); end
    ihit = 1'b1; @(posedge CLK); #1;
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL jal_pc got=%h exp=100", pc); end
    retire_fetch(32'h03E0_0008, 1'b0, 1'b0, 1'b1, 32'h8000_0000);  // JR
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL jr_pc got=%h exp=80000000", pc); end
    checks++; if (instr_count !== 32'd7) begin failures++; $display("FAIL jr_count got=%0d exp=7", instr_count); end
  endtask

  task automatic test_wrap();
    retire_fetch(32'h03E0_0008, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jr2_pc got=%h exp=fffffffc", pc); end
    @(negedge CLK); idle(); ihit = 1'b1; dhit = 1'b1; imemload = 32'h0022_1821; #1;
    checks++; if (dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin failures++; $display("FAIL wrap_dreq got=%0b%0b exp=00", dmemREN, dmemWEN); end
    checks++; if (commit !== 1'b1) begin failures++; $display("FAIL wrap_commit got=%0b exp=1", commit); end
    @(posedge CLK); #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (instr_count !== 32'd9) begin failures++; $display("FAIL wrap_count got=%0d exp=9", instr_count); end
  endtask

  task automatic test_reset_mid_data();
    @(negedge CLK); idle(); ihit = 1'b1; dMemWr = 1'b1; imemload = 32'hAC43_0000;
    @(posedge CLK);
    @(negedge CLK); ihit = 1'b0; #1;
    checks++; if (dmemWEN !== 1'b1) begin failures++; $display("FAIL sw_wen got=%0b exp=1", dmemWEN); end
    nRST = 1'b0; dhit = 1'b1; #1;
    checks++; if (dmemWEN !== 1'b0 || commit !== 1'b0) begin failures++; $display("FAIL midrst wen=%0b commit=%0b exp 0/0", dmemWEN, commit); end
    @(posedge CLK);
    @(negedge CLK); idle(); nRST = 1'b1; #1;
    checks++; if (pc !== 32'h0 || instr_count !== 32'h0) begin failures++; $display("FAIL midrst_state pc=%h cnt=%0d exp 0/0", pc, instr_count); end
    checks++; if (imemREN !== 1'b1 || dmemWEN !== 1'b0) begin failures++; $display("FAIL midrst_req got=%0b%0b exp=10", imemREN, dmemWEN); end
  endtask

  task automatic test_halt();
    retire_fetch(32'h0022_1821, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK); idle(); ihit = 1'b1; Halt = 1'b1; imemload = 32'hFFFF_FFFF; #1;
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL halt_commit got=%0b exp=0", commit); end
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); idle(); ihit = 1'b1; dhit = 1'b1; dMemRe = 1'b1; #1;
      checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0b exp=1", halt); end
      checks++; if (imemREN !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0 || commit !== 1'b0) begin
        failures++; $display("FAIL halt_req got=%0b%0b%0b%0b exp=0000", imemREN, dmemREN, dmemWEN, commit); end
      checks++; if (pc !== 32'h4 || instr_count !== 32'd1) begin failures++; $display("FAIL halt_frozen pc=%h cnt=%0d exp 4/1", pc, instr_count); end
    end
    @(negedge CLK); idle(); nRST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (halt !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL halt_clear halt=%0b pc=%h exp 0/0", halt, pc); end
    @(negedge CLK); nRST = 1'b1; #1;
    checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL halt_refetch got=%0b exp=1", imemREN); end
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    test_reset();
    test_alu_delayed();
    test_load();
    test_branch_jumps();
    test_wrap();
    test_reset_mid_data();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
